paralelo_serie_tx: RTL and testbench
====================================

# paralelo_serie_tx

Transmit-side parallel-to-serial converter for the PHY link. It accepts 8-bit words with a valid qualifier in the clk_f domain and emits them MSB-first as a serial bit stream in the clk_8f domain. After reset it first sends a burst of 0xBC comma words so the far-end serial-to-parallel receiver can lock. From then on it sends 0xBC whenever no valid word is offered. It sits between the TX data path and the physical serial line and mirrors the receive-side deserializer.

## Interface
- SYNC_WORDS, 4: number of comma words loaded in SYNC state before DATA state is entered; range 1..15.
- IDLE_WORD, 8'hBC: comma/idle word, used during sync and whenever valid_in=0.

- clk_f  input  1  word clock. Every rising edge coincides with a clk_8f rising edge.
- clk_8f  input  1  bit clock at 8× clk_f, phase-aligned to clk_f.
- reset  input  1  reset, synchronous, active-low; clock clk_f. Deassertion is synchronous to clk_f. The clk_8f-domain registers sample the same signal on their own edges.
- data_in  input  8  word to transmit; sampled on clk_f when valid_in=1 and ready_out=1.
- valid_in  input  1  data_in qualifier.
- ready_out  output  1  high in DATA state only; upstream words are ignored while low.
- data_out  output  1  serial stream, MSB first, registered on clk_8f.
- err_out  output  1  one-clk_f pulse: an accepted data word equalled IDLE_WORD.

## Operation
- clk_f domain, state machine SYNC → DATA, with a 4-bit sync_cnt:
  - Reset values: state=SYNC, sync_cnt=0, tx_word=IDLE_WORD, ready_out=0, err_out=0.
  - SYNC: each edge sets tx_word<=IDLE_WORD and increments sync_cnt. On the edge where sync_cnt==SYNC_WORDS-1, go to DATA and set ready_out<=1.
  - DATA: if valid_in=1, tx_word<=data_in; otherwise tx_word<=IDLE_WORD. err_out<=(valid_in && data_in==IDLE_WORD). The word is still transmitted unchanged.
  - DATA is left only by reset.
- clk_8f domain:
  - Reset values: bit_cnt=7, shift_reg=IDLE_WORD, data_out=0.
  - At edges with bit_cnt==7: shift_reg<=tx_word and data_out<=tx_word[7]. This samples the pre-edge tx_word at the coincident clk_f edge.
  - Other edges: data_out<=shift_reg[bit_cnt].
  - bit_cnt decrements every edge, wrapping 0→7.
- Because reset is released on a clk_f edge, the first non-reset clk_8f edge always has bit_cnt==7. Word boundaries therefore stay aligned to clk_f.
- Output stream has no gaps. Every group of 8 clk_8f bits is either a data word or IDLE_WORD.

## Timing
- Edge n means the nth rising clk_f edge with reset=1 after release.
- Serialization: edge n starts serializing the tx_word value held before edge n. The MSB appears on data_out after edge n and the LSB after the 7th following clk_8f edge.
- Sync burst:
  - Edges 1..SYNC_WORDS+1 serialize IDLE_WORD (SYNC_WORDS+1 commas; 5 with default).
  - ready_out rises after edge SYNC_WORDS.
  - The first data word can be sampled at edge SYNC_WORDS+1.
- Latency: a word sampled at clk_f edge k has its MSB on data_out after edge k+1 and its LSB 7 clk_8f cycles later.
- Throughput: one word per clk_f cycle; back-to-back valid words are supported.
- err_out: high for exactly the clk_f cycle following the sampling edge.
- Reset mid-operation:
  - At the first clk_8f edge sampling reset=0, data_out goes 0 and bit_cnt goes 7. The partial word is truncated.
  - At the first clk_f edge sampling reset=0, all clk_f state returns to reset values.
  - After release the full sync burst repeats.
- valid_in while ready_out=0: the word is dropped with no error indication; upstream must honour ready_out.

## Test plan
- Reset held low 3 clk_f → data_out=0, ready_out=0, err_out=0 throughout; bit_cnt=7.
- Release with valid_in=0 → data_out repeats 1,0,1,1,1,1,0,0 per clk_f; ready_out=1 after edge 4; 5 commas precede any data.
- Present data_in=0xA5 with valid_in=1 at edge 5 → bits 1,0,1,0,0,1,0,1 after edge 6, then 0xBC pattern.
- Back-to-back 0x01, 0xFF, 0x7E at edges 5,6,7 → 24 contiguous bits 00000001 11111111 01111110, no comma between words.
- Present data_in=0xBC with valid_in=1 in DATA → 0xBC serialized; err_out=1 for exactly one clk_f cycle.
- Drive reset=0 at clk_8f bit 3 of word 0x5A, hold for 1 clk_f, then release → data_out=0 from that clk_8f edge; after release, 5 commas then ready_out=1; loopback into the receive-side deserializer recovers subsequent words exactly.

Source files
------------

// File: rtl/paralelo_serie_tx.sv
// Parallel-to-serial transmitter: 8-bit words on clk_f go out MSB-first on clk_8f.
// A comma burst precedes data after every reset, and commas fill idle word slots.
`timescale 1ns/1ps
module paralelo_serie_tx #(
   parameter int unsigned SYNC_WORDS = 4,
   parameter logic [7:0]  IDLE_WORD  = 8'hBC
) (
   input  logic       clk_f,
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       err_out
);

   typedef enum logic [0:0] {
      ST_SYNC = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

   state_t     state_q,    state_d;
   logic [3:0] sync_cnt_q, sync_cnt_d;
   logic [7:0] tx_word_q,  tx_word_d;
   logic       ready_q,    ready_d;
   logic       err_q,      err_d;

   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [7:0] shift_q,    shift_d;
   logic       dout_q,     dout_d;

   // Word-level next state: comma burst in SYNC, then one word per clk_f in DATA
   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      tx_word_d  = tx_word_q;
      ready_d    = ready_q;
      err_d      = 1'b0;
      case (state_q)
         ST_SYNC: begin
            tx_word_d  = IDLE_WORD;
            sync_cnt_d = sync_cnt_q + 4'd1;
            if (sync_cnt_q == SYNC_LAST) begin
               state_d = ST_DATA;
               ready_d = 1'b1;
            end else begin
               state_d = ST_SYNC;
               ready_d = 1'b0;
            end
         end
         ST_DATA: begin
            ready_d = 1'b1;
            if (valid_in) begin
               tx_word_d = data_in;
               err_d     = (data_in == IDLE_WORD);
            end else begin
               tx_word_d = IDLE_WORD;
               err_d     = 1'b0;
            end
         end
         default: begin
            state_d    = ST_SYNC;
            sync_cnt_d = 4'd0;
            tx_word_d  = IDLE_WORD;
            ready_d    = 1'b0;
         end
      endcase
   end

   // Word-domain registers
   always_ff @(posedge clk_f) begin
      if (!reset) begin
         state_q    <= ST_SYNC;
         sync_cnt_q <= 4'd0;
         tx_word_q  <= IDLE_WORD;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         tx_word_q  <= tx_word_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
      end
   end

   // Bit-level next state; at bit_cnt==7 this edge coincides with a clk_f edge,
   // so tx_word_q still holds the word chosen on the previous clk_f cycle
   always_comb begin
      bit_cnt_d = bit_cnt_q - 3'd1;
      if (bit_cnt_q == 3'd7) begin
         shift_d = tx_word_q;
         dout_d  = tx_word_q[7];
      end else begin
         shift_d = shift_q;
         dout_d  = shift_q[bit_cnt_q];
      end
   end

   // Bit-domain registers
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         bit_cnt_q <= 3'd7;
         shift_q   <= IDLE_WORD;
         dout_q    <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
      end
   end

   assign ready_out = ready_q;
   assign err_out   = err_q;
   assign data_out  = dout_q;

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Scoreboard bench for paralelo_serie_tx: a word-level model queues expected
// serial bits and ready/err values; monitors pop and compare on falling edges.
`timescale 1ns/1ps
module tb_paralelo_serie_tx;

   localparam int         SYNC_WORDS = 4;
   localparam logic [7:0] IDLE       = 8'hBC;

   logic       clk_f    = 1'b0;
   logic       clk_8f   = 1'b0;
   logic       reset    = 1'b0;
   logic [7:0] data_in  = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic       data_out;
   logic       err_out;

   int n_checks = 0;
   int n_pass   = 0;

   bit         bitq[$];
   logic [1:0] ctlq[$];
   int         edge_n  = 0;
   logic       rst_smp = 1'b0;
   bit         mon_on  = 1'b0;
   logic [7:0] sel_word;
   bit         acc;
   logic [1:0] ctl;

   paralelo_serie_tx #(.SYNC_WORDS(SYNC_WORDS), .IDLE_WORD(IDLE)) dut (
      .clk_f     (clk_f),
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .err_out   (err_out)
   );

   // Both clocks from one process so their rising edges coincide exactly
   initial begin
      forever begin
         for (int i = 0; i < 8; i++) begin
            #5 clk_8f = 1'b1;
            if (i == 0) clk_f = 1'b1;
            #5 clk_8f = 1'b0;
            if (i == 3) clk_f = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: expected data missing at t=%0t", name, $time);
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
   endtask

   // Reference model: which word each clk_f edge picks, and the ready/err it implies
   always @(posedge clk_f) begin
      if (!reset) begin
         edge_n = 0;
         ctlq.push_back(2'b00);
      end else begin
         edge_n++;
         if (edge_n == 1) push_word(IDLE);
         acc      = valid_in && (edge_n > SYNC_WORDS);
         sel_word = acc ? data_in : IDLE;
         push_word(sel_word);
         ctlq.push_back({(edge_n >= SYNC_WORDS), (acc && data_in == IDLE)});
      end
   end

   always @(posedge clk_8f) begin
      rst_smp = reset;
      mon_on  = 1'b1;
   end

   // Serial monitor: reset edges force 0 and discard any queued word
   always @(negedge clk_8f) begin
      if (mon_on) begin
         if (!rst_smp) begin
            check("data_out_in_reset", data_out, 1'b0);
            bitq.delete();
         end else if (bitq.size() == 0) begin
            fail_now("data_out_underflow");
         end else begin
            check("data_out_bit", data_out, bitq.pop_front());
         end
      end
   end

   always @(negedge clk_f) begin
      if (ctlq.size() == 0) begin
         fail_now("ctl_underflow");
      end else begin
         ctl = ctlq.pop_front();
         check("ready_out", ready_out, ctl[1]);
         check("err_out",   err_out,   ctl[0]);
      end
   end

   task automatic cycle(input logic v, input logic [7:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk_f);
      #1;
   endtask

   task automatic rand_cycles(input int n);
      logic       v;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 7) == 0) ? IDLE : 8'($urandom);
         cycle(v, d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk_f);
      // release inside the last clk_8f slot so the first live edge is a clk_f edge
      #72 reset = 1'b1;
      repeat (4) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h01);
      cycle(1'b1, 8'hFF);
      cycle(1'b1, 8'h7E);
      cycle(1'b0, 8'h00);
      cycle(1'b1, IDLE);
      cycle(1'b0, 8'h00);
      rand_cycles(60);

      cycle(1'b1, 8'h5A);
      cycle(1'b0, 8'h00);
      #34 reset = 1'b0;
      @(posedge clk_f);
      #71 reset = 1'b1;
      rand_cycles(8);
      rand_cycles(40);
      repeat (3) cycle(1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
